// File: rtl/hb_dec_mc.sv
// hb_dec_mc: multi-channel 7-tap halfband decimator.
// One stage decimates by 2; mode=1 cascades a second identical stage for /4.
// All lanes share the input strobe, the per-stage phase and the output strobe.
module hb_dec_mc #(
    parameter int WIDTH = 24,
    parameter int NCH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   bypass,
    input  logic                   mode,
    input  logic                   stb_in,
    input  logic [NCH*WIDTH-1:0]   data_in,
    output logic                   stb_out,
    output logic [NCH*WIDTH-1:0]   data_out
);
    logic                  run_q;
    logic                  mode_q;
    logic                  byp_q;
    logic                  run_rise;
    logic                  acc;
    logic                  s1_clr;
    logic                  s1_stb_in;
    logic                  s1_stb;
    logic                  s2_clr;
    logic                  s2_stb_in;
    logic                  s2_stb;
    logic [NCH*WIDTH-1:0]  s1_dout;
    logic [NCH*WIDTH-1:0]  s2_dout;
    logic                  stb_out_q;
    logic                  stb_out_d;
    logic [NCH*WIDTH-1:0]  data_out_q;
    logic [NCH*WIDTH-1:0]  data_out_d;

    // A strobe arriving together with the rising edge of run is not accepted.
    assign run_rise = run & ~run_q;
    assign acc      = run & run_q & stb_in;

    // Track run and latch the operating mode only when run rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            mode_q <= 1'b0;
            byp_q  <= 1'b0;
        end else begin
            run_q <= run;
            if (run_rise) begin
                mode_q <= mode;
                byp_q  <= bypass;
            end
        end
    end

    // Filter state is held at zero while stopped or bypassed; stage 2 only runs in /4 mode.
    assign s1_clr    = ~run | byp_q;
    assign s1_stb_in = acc & ~byp_q;
    assign s2_clr    = ~run | byp_q | ~mode_q;
    assign s2_stb_in = s1_stb & mode_q;

    hb_dec_stage #(.WIDTH(WIDTH), .NCH(NCH)) u_stage1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (s1_clr),
        .stb_i  (s1_stb_in),
        .din_i  (data_in),
        .stb_o  (s1_stb),
        .dout_o (s1_dout)
    );

    hb_dec_stage #(.WIDTH(WIDTH), .NCH(NCH)) u_stage2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (s2_clr),
        .stb_i  (s2_stb_in),
        .din_i  (s1_dout),
        .stb_o  (s2_stb),
        .dout_o (s2_dout)
    );

    // Select the output source; anything still in flight when run drops is discarded.
    always_comb begin
        stb_out_d  = 1'b0;
        data_out_d = data_out_q;
        if (run) begin
            if (byp_q) begin
                stb_out_d = acc;
                if (acc) data_out_d = data_in;
            end else if (mode_q) begin
                stb_out_d = s2_stb;
                if (s2_stb) data_out_d = s2_dout;
            end else begin
                stb_out_d = s1_stb;
                if (s1_stb) data_out_d = s1_dout;
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_out_q  <= 1'b0;
            data_out_q <= '0;
        end else begin
            stb_out_q  <= stb_out_d;
            data_out_q <= data_out_d;
        end
    end

    assign stb_out  = stb_out_q;
    assign data_out = data_out_q;
endmodule

// One halfband /2 stage: delay line updates on the accepted strobe (T), the exact
// sum registers at T+1, and the rounded/saturated value is presented combinationally
// from the sum register so the next consumer registers it at T+2.
module hb_dec_stage #(
    parameter int WIDTH = 24,
    parameter int NCH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   stb_i,
    input  logic [NCH*WIDTH-1:0]   din_i,
    output logic                   stb_o,
    output logic [NCH*WIDTH-1:0]   dout_o
);
    localparam int SW = WIDTH + 6;

    logic phase_q;
    logic pend_q;
    logic vld_q;

    // Phase toggles per accepted sample; only odd-phase samples produce an output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            pend_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else if (clr_i) begin
            phase_q <= 1'b0;
            pend_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            pend_q <= stb_i & phase_q;
            vld_q  <= pend_q;
            if (stb_i) phase_q <= ~phase_q;
        end
    end

    assign stb_o = vld_q;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            logic signed [WIDTH-1:0] x_in;
            logic signed [WIDTH-1:0] line_q [7];
            logic signed [SW-1:0]    e0, e2, e3, e4, e6;
            logic signed [SW-1:0]    sum_d;
            logic signed [SW-1:0]    sum_q;
            logic signed [SW-1:0]    rnd;
            logic                    ovf;

            assign x_in = din_i[gi*WIDTH +: WIDTH];

            // Delay line x[n]..x[n-6], shifted on each accepted sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < 7; k++) line_q[k] <= '0;
                end else if (clr_i) begin
                    for (int k = 0; k < 7; k++) line_q[k] <= '0;
                end else if (stb_i) begin
                    line_q[0] <= x_in;
                    for (int k = 6; k > 0; k--) line_q[k] <= line_q[k-1];
                end
            end

            // Taps {-1,0,9,16,9,0,-1}: multiplies reduce to shifts and adds.
            assign e0 = SW'(line_q[0]);
            assign e2 = SW'(line_q[2]);
            assign e3 = SW'(line_q[3]);
            assign e4 = SW'(line_q[4]);
            assign e6 = SW'(line_q[6]);
            assign sum_d = (e2 <<< 3) + e2 + (e3 <<< 4) + (e4 <<< 3) + e4 - e0 - e6;

            // Capture the exact sum only for samples that will produce an output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q <= '0;
                end else if (clr_i) begin
                    sum_q <= '0;
                end else if (pend_q) begin
                    sum_q <= sum_d;
                end
            end

            // Round half up, then clamp to the WIDTH-bit signed range.
            assign rnd = (sum_q + SW'(16)) >>> 5;
            assign ovf = (rnd[SW-1:WIDTH-1] != {(SW-WIDTH+1){rnd[SW-1]}});
            assign dout_o[gi*WIDTH +: WIDTH] = !ovf      ? rnd[WIDTH-1:0] :
                                               rnd[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                                           {1'b0, {(WIDTH-1){1'b1}}};
        end
    endgenerate
endmodule
